// File: rtl/mlp_pkg.sv
// Shared types and arithmetic helpers for the MLP datapath.
// Holds the default widths, the layer-controller state encoding and
// the scale-and-saturate step applied to an accumulated dot product.
package mlp_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int WADDR_W   = 16;
    localparam int FRAC_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } layer_state_t;

    // Bounds of a DATA_W signed value, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Drop the fractional bits, then clamp into the neuron value range.
    function automatic logic signed [DATA_W-1:0] scale_sat(
        input logic signed [ACC_W-1:0] acc,
        input int                      frac_bits
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> frac_bits;
        if (shifted > SAT_MAX) begin
            scale_sat = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            scale_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            scale_sat = shifted[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Multiply-accumulate register for one output neuron.
// clear has priority over en; the product is full precision and is
// sign-extended into a wrapping accumulator.
module neuron_mac #(
    parameter int DATA_W = mlp_pkg::DATA_W,
    parameter int ACC_W  = mlp_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] product;

    assign product = a * b;

    // Accumulator register: clear at the start of a neuron, add while streaming.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
        end
    end

endmodule

// File: rtl/neuron_layer_ctrl.sv
// Fully-connected layer sequencer: for each output neuron it streams the
// inputs and weights through a MAC, scales/saturates the sum and writes it
// back to neuron memory. Sole driver of the memory read and write ports.
// Optional ReLU on the written value: define NEURON_CTRL_RELU_EN.
module neuron_layer_ctrl #(
    parameter int ADDR_W    = mlp_pkg::ADDR_W,
    parameter int DATA_W    = mlp_pkg::DATA_W,
    parameter int ACC_W     = mlp_pkg::ACC_W,
    parameter int WADDR_W   = mlp_pkg::WADDR_W,
    parameter int FRAC_BITS = mlp_pkg::FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        in_base,
    input  logic [ADDR_W-1:0]        in_count,
    input  logic [ADDR_W-1:0]        out_base,
    input  logic [ADDR_W-1:0]        out_count,
    input  logic [WADDR_W-1:0]       w_base,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic signed [DATA_W-1:0] mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    output logic [WADDR_W-1:0]       w_addr,
    input  logic signed [DATA_W-1:0] w_data
);

    import mlp_pkg::*;

    localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

    layer_state_t state, state_next;

    logic [ADDR_W-1:0]        cfg_in_base, cfg_in_count, cfg_out_base, cfg_out_count;
    logic [ADDR_W-1:0]        i_cnt, j_cnt;
    logic [WADDR_W-1:0]       wptr;
    logic [ADDR_W:0]          in_end, out_end;
    logic                     cfg_bad;
    logic                     mac_clear, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] scaled, activated;

    // Range ends carry one extra bit so a range touching the top of memory
    // is representable and overlap tests cannot wrap.
    assign in_end  = {1'b0, in_base}  + {1'b0, in_count};
    assign out_end = {1'b0, out_base} + {1'b0, out_count};
    assign cfg_bad = (in_count == '0) || (out_count == '0)
                  || (in_end > ADDR_SPAN) || (out_end > ADDR_SPAN)
                  || (({1'b0, in_base} < out_end) && ({1'b0, out_base} < in_end));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !cfg_bad) state_next = FETCH;
            FETCH:   if (i_cnt == cfg_in_count - ADDR_W'(1)) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   state_next = (j_cnt == cfg_out_count - ADDR_W'(1)) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch, loop counters, weight pointer and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_in_base   <= '0;
            cfg_in_count  <= '0;
            cfg_out_base  <= '0;
            cfg_out_count <= '0;
            i_cnt         <= '0;
            j_cnt         <= '0;
            wptr          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            cfg_in_base   <= in_base;
                            cfg_in_count  <= in_count;
                            cfg_out_base  <= out_base;
                            cfg_out_count <= out_count;
                            i_cnt         <= '0;
                            j_cnt         <= '0;
                            wptr          <= w_base;
                            busy          <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    i_cnt <= i_cnt + ADDR_W'(1);
                    // Weights are laid out neuron after neuron, so the pointer
                    // simply keeps counting across output neurons.
                    wptr  <= wptr + WADDR_W'(1);
                end
                WRITE: begin
                    i_cnt <= '0;
                    j_cnt <= j_cnt + ADDR_W'(1);
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read data lags the address by one cycle: the first FETCH of a neuron
    // clears, later FETCH cycles and DRAIN accumulate the previous product.
    assign mac_clear = (state == FETCH) && (i_cnt == '0);
    assign mac_en    = ((state == FETCH) && (i_cnt != '0)) || (state == DRAIN);

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (mem_rd_data),
        .b     (w_data),
        .acc   (acc)
    );

    assign scaled = scale_sat(acc, FRAC_BITS);

`ifdef NEURON_CTRL_RELU_EN
    assign activated = scaled[DATA_W-1] ? '0 : scaled;
`else
    assign activated = scaled;
`endif

    // Memory-side outputs are held at zero outside the states that use them.
    assign mem_rd_addr = (state == FETCH) ? cfg_in_base + i_cnt : '0;
    assign w_addr      = (state == FETCH) ? wptr : '0;
    assign mem_wr_en   = (state == WRITE);
    assign mem_wr_addr = (state == WRITE) ? cfg_out_base + j_cnt : '0;
    assign mem_wr_data = (state == WRITE) ? activated : '0;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Self-checking bench for neuron_layer_ctrl: behavioural neuron memory and
// weight ROM, directed cases plus randomized layers against a dot-product
// model. Expected values follow NEURON_CTRL_RELU_EN when it is defined.
module tb_neuron_layer_ctrl;

    localparam int FRAC = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [11:0]        in_base, in_count, out_base, out_count;
    logic [15:0]        w_base;
    logic               busy, done, err;
    logic [11:0]        mem_rd_addr;
    logic signed [15:0] mem_rd_data;
    logic               mem_wr_en;
    logic [11:0]        mem_wr_addr;
    logic [15:0]        mem_wr_data;
    logic [15:0]        w_addr;
    logic signed [15:0] w_data;

    logic signed [15:0] mem [4096];
    logic signed [15:0] rom [65536];

    int wr_addr_q[$];
    int wr_data_q[$];
    int applied  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int checks   = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    neuron_layer_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_base     (in_base),
        .in_count    (in_count),
        .out_base    (out_base),
        .out_count   (out_count),
        .w_base      (w_base),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .w_addr      (w_addr),
        .w_data      (w_data)
    );

    // Registered memory/ROM reads; writes are logged and applied later.
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_rd_addr];
        w_data      <= rom[w_addr];
        if (mem_wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(mem_wr_addr));
            wr_data_q.push_back(int'($signed(mem_wr_data)));
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected neuron j: dot product, arithmetic shift, clamp, optional ReLU.
    function automatic int model_out(input int ib, input int ic, input int wb, input int j);
        longint s = 0;
        for (int i = 0; i < ic; i++)
            s += longint'(mem[ib+i]) * longint'(rom[(wb + j*ic + i) % 65536]);
        s = s >>> FRAC;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`ifdef NEURON_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    task automatic apply_writes();
        while (applied < wr_addr_q.size()) begin
            mem[wr_addr_q[applied]] = 16'(wr_data_q[applied]);
            applied++;
        end
    endtask

    task automatic fill_random(input int ib, input int ic, input int oc, input int wb);
        for (int i = 0; i < ic; i++)      mem[ib+i] = 16'($urandom);
        for (int i = 0; i < ic*oc; i++)   rom[(wb+i) % 65536] = 16'($urandom);
    endtask

    task automatic run_layer(input int ib, input int ic, input int ob, input int oc, input int wb);
        int exp_q[$];
        int base_w, n, k;
        for (int j = 0; j < oc; j++) exp_q.push_back(model_out(ib, ic, wb, j));
        base_w = wr_addr_q.size();
        @(negedge clk);
        in_base = 12'(ib); in_count = 12'(ic); out_base = 12'(ob);
        out_count = 12'(oc); w_base = 16'(wb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Configuration must have been captured at the accept edge.
        in_base = 12'($urandom); in_count = 12'($urandom); out_base = 12'($urandom);
        out_count = 12'($urandom); w_base = 16'($urandom);
        check("busy_after_accept", busy, 1);
        n = oc * (ic + 2) + 1;
        k = 0;
        while (done !== 1'b1 && k < n + 8) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", k, n);
        check("busy_at_done", busy, 0);
        check("write_count", wr_addr_q.size() - base_w, oc);
        for (int j = 0; j < oc && base_w + j < wr_addr_q.size(); j++) begin
            check("wr_addr", wr_addr_q[base_w+j], ob + j);
            check("wr_data", wr_data_q[base_w+j], exp_q[j]);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        apply_writes();
    endtask

    task automatic reject(input int ib, input int ic, input int ob, input int oc, input string tag);
        int w0;
        w0 = wr_addr_q.size();
        @(negedge clk);
        in_base = 12'(ib); in_count = 12'(ic); out_base = 12'(ob);
        out_count = 12'(oc); w_base = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        @(negedge clk);
        check({tag, "_err_pulse"}, err, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_no_write"}, wr_addr_q.size() - w0, 0);
    endtask

    initial begin
        int exp0, w0, d0, e0, k, n;
        reset = 1'b0; start = 1'b0;
        in_base = '0; in_count = '0; out_base = '0; out_count = '0; w_base = '0;
        for (int i = 0; i < 4096; i++)  mem[i] = '0;
        for (int i = 0; i < 65536; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_w_addr", w_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic pass: 8*4 + 8*(-3) = 8, times 256, shifted by 8 -> 8.
        for (int i = 0; i < 8; i++)  mem[i] = 16'sd4;
        for (int i = 8; i < 16; i++) mem[i] = -16'sd3;
        for (int i = 0; i < 16; i++) rom[i] = 16'sd256;
        run_layer(0, 16, 32, 1, 0);
        check("basic_mem32", mem[32], 8);

        // Two neurons: second uses the next 16 weights (-256).
        for (int i = 16; i < 32; i++) rom[i] = -16'sd256;
        run_layer(0, 16, 32, 2, 0);
        check("multi_mem32", mem[32], 8);
`ifdef NEURON_CTRL_RELU_EN
        check("multi_mem33", mem[33], 0);
`else
        check("multi_mem33", mem[33], -8);
`endif

        // Saturation in both directions.
        for (int i = 0; i < 16; i++)  mem[i] = 16'sd32767;
        for (int i = 40; i < 56; i++) rom[i] = 16'sd32767;
        run_layer(0, 16, 32, 1, 40);
        check("sat_pos", mem[32], 32767);
        for (int i = 0; i < 16; i++) mem[i] = -16'sd32768;
        run_layer(0, 16, 32, 1, 40);
`ifdef NEURON_CTRL_RELU_EN
        check("sat_neg", mem[32], 0);
`else
        check("sat_neg", mem[32], -32768);
`endif

        // Rejected configurations.
        reject(0, 0, 32, 1, "rej_in_count0");
        reject(0, 4, 32, 0, "rej_out_count0");
        reject(0, 16, 10, 1, "rej_overlap");
        reject(0, 16, 4090, 8, "rej_out_range");
        reject(4090, 8, 0, 1, "rej_in_range");

        // Boundary acceptances: output ending exactly at the top of memory,
        // adjacent ranges, and weight pointer wrapping past 65535.
        fill_random(0, 4, 1, 1000);
        run_layer(0, 4, 4095, 1, 1000);
        fill_random(200, 8, 2, 65533);
        run_layer(200, 8, 208, 2, 65533);

        // Randomized layers.
        for (int t = 0; t < 6; t++) begin
            int ib, ic, ob, oc, wb;
            ic = $urandom_range(1, 12);
            oc = $urandom_range(1, 4);
            ib = $urandom_range(0, 1000);
            ob = ib + ic + $urandom_range(0, 40);
            wb = $urandom_range(0, 65535);
            fill_random(ib, ic, oc, wb);
            run_layer(ib, ic, ob, oc, wb);
        end

        // Asynchronous reset during FETCH of the second of three neurons.
        fill_random(0, 8, 3, 500);
        exp0 = model_out(0, 8, 500, 0);
        w0 = wr_addr_q.size();
        @(negedge clk);
        in_base = 12'd0; in_count = 12'd8; out_base = 12'd50;
        out_count = 12'd3; w_base = 16'd500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (wr_addr_q.size() == w0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("abort_first_write_seen", wr_addr_q.size() - w0, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr_en", mem_wr_en, 0);
        check("abort_rd_addr", mem_rd_addr, 0);
        repeat (3) @(negedge clk);
        check("abort_write_count", wr_addr_q.size() - w0, 1);
        reset = 1'b1;
        apply_writes();
        check("abort_mem50_kept", mem[50], exp0);
        run_layer(0, 8, 50, 3, 500);

        // start held high through a run: one run, then released in IDLE.
        fill_random(0, 3, 2, 7);
        n  = 2 * (3 + 2) + 1;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_addr_q.size();
        @(negedge clk);
        in_base = 12'd0; in_count = 12'd3; out_base = 12'd60;
        out_count = 12'd2; w_base = 16'd7; start = 1'b1;
        @(negedge clk);
        k = 0;
        while (done !== 1'b1 && k < n + 8) begin
            @(negedge clk);
            k++;
        end
        check("held_done_latency", k, n);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("held_busy_idle", busy, 0);
        check("held_done_pulses", done_cnt - d0, 1);
        check("held_writes", wr_addr_q.size() - w0, 2);
        check("held_no_err", err_cnt - e0, 0);

        // Held again and still high when back in IDLE: a second run starts.
        start = 1'b1;
        @(negedge clk);
        k = 0;
        while (done !== 1'b1 && k < n + 8) begin
            @(negedge clk);
            k++;
        end
        check("rerun_first_done", done, 1);
        @(negedge clk);
        check("rerun_busy", busy, 1);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < n + 8) begin
            @(negedge clk);
            k++;
        end
        check("rerun_second_done", done, 1);
        repeat (2) @(negedge clk);
        check("rerun_done_pulses", done_cnt - d0, 3);
        check("rerun_writes", wr_addr_q.size() - w0, 6);
        apply_writes();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
